// File: rtl/mem_seq_if.sv
// mem_seq_if: bundles the mem_seq access-launch request, byte-wide data
// memory port, status and pointer writeback signals.
//   Request   : start, op[2:0], use_sp, ptr_ai[15:0], ptr_ro[15:0], wdata[15:0]
//   Memory    : dm_req, dm_we, dm_addr[15:0], dm_wdata[7:0] (to memory)
//               dm_rdata[7:0], dm_ready (from memory)
//   Status    : busy, done, rdata[15:0]
//   Writeback : ptr_we, sp_we, wb_data[15:0]
// slave  : the sequencer side (mem_seq).
// master : the environment side (requester plus data memory).
interface mem_seq_if;
    logic        start;
    logic [2:0]  op;
    logic        use_sp;
    logic [15:0] ptr_ai;
    logic [15:0] ptr_ro;
    logic [15:0] wdata;

    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata;
    logic        dm_ready;

    logic        busy;
    logic        done;
    logic [15:0] rdata;

    logic        ptr_we;
    logic        sp_we;
    logic [15:0] wb_data;

    modport slave (
        input  start, op, use_sp, ptr_ai, ptr_ro, wdata,
        input  dm_rdata, dm_ready,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output busy, done, rdata,
        output ptr_we, sp_we, wb_data
    );

    modport master (
        output start, op, use_sp, ptr_ai, ptr_ro, wdata,
        output dm_rdata, dm_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  busy, done, rdata,
        input  ptr_we, sp_we, wb_data
    );
endinterface

// File: rtl/mem_seq.sv
// mem_seq: load/store/push/pop sequencer driving a byte-wide data memory.
// A launch in IDLE captures the request; one byte access (two for PUSH2 /
// POP2) is performed with unbounded dm_ready wait states, then a single
// DONE cycle presents the pointer or SP writeback.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : mem_seq_if.slave -- request, memory port, status, writeback
// Memory-side and writeback outputs are decoded from the registered state
// and captured request only, so they are glitch-free against dm_ready and
// fall to zero the instant rst is asserted.
module mem_seq (
    input  logic     clk,
    input  logic     rst,
    mem_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_LD_RO   = 3'd0,
        OP_LD_POST = 3'd1,
        OP_LD_PRE  = 3'd2,
        OP_ST_RO   = 3'd3,
        OP_ST_POST = 3'd4,
        OP_ST_PRE  = 3'd5,
        OP_PUSH2   = 3'd6,
        OP_POP2    = 3'd7
    } op_e;

    // Registered state and captured request
    state_e      state_q,  state_d;
    op_e         op_q,     op_d;
    logic        use_sp_q, use_sp_d;
    logic [15:0] ptr_ai_q, ptr_ai_d;
    logic [15:0] ptr_ro_q, ptr_ro_d;
    logic [15:0] wdata_q,  wdata_d;
    logic [15:0] rdata_q,  rdata_d;
    // POP2 high byte, parked so rdata only changes when the whole load ends
    logic [7:0]  hi_q,     hi_d;

    // Decoded request attributes
    logic        two_byte;
    logic        is_store;
    logic        is_load;
    logic        addr_from_ai;
    logic        ptr_update;

    // Output drivers
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [7:0]  dm_wdata;
    logic        done;
    logic        ptr_we;
    logic        sp_we;
    logic [15:0] wb_data;
    logic        xfer;

    always_comb begin
        two_byte     = (op_q == OP_PUSH2) || (op_q == OP_POP2);
        is_store     = (op_q == OP_ST_RO) || (op_q == OP_ST_POST) ||
                       (op_q == OP_ST_PRE) || (op_q == OP_PUSH2);
        is_load      = !is_store;
        // Post-modify ops and PUSH2 access at the pre-calculation pointer
        addr_from_ai = (op_q == OP_LD_POST) || (op_q == OP_ST_POST) ||
                       (op_q == OP_PUSH2);
        ptr_update   = (op_q == OP_LD_POST) || (op_q == OP_LD_PRE) ||
                       (op_q == OP_ST_POST) || (op_q == OP_ST_PRE);
    end

    // Output decode
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        done     = 1'b0;
        ptr_we   = 1'b0;
        sp_we    = 1'b0;
        wb_data  = '0;

        case (state_q)
            ACC0: begin
                dm_req   = 1'b1;
                dm_we    = is_store;
                dm_addr  = addr_from_ai ? ptr_ai_q : ptr_ro_q;
                dm_wdata = is_store ? wdata_q[7:0] : 8'h00;
            end
            ACC1: begin
                dm_req   = 1'b1;
                dm_we    = is_store;
                // PUSH2 grows downward from ptr_ai, POP2 reads upward from ptr_ro
                dm_addr  = (op_q == OP_PUSH2) ? (ptr_ai_q - 16'd1)
                                              : (ptr_ro_q + 16'd1);
                dm_wdata = is_store ? wdata_q[15:8] : 8'h00;
            end
            DONE: begin
                done = 1'b1;
                if (ptr_update) begin
                    wb_data = ptr_ro_q;
                    sp_we   = use_sp_q;
                    ptr_we  = !use_sp_q;
                end else if (op_q == OP_PUSH2) begin
                    wb_data = ptr_ai_q - 16'd2;
                    sp_we   = 1'b1;
                end else if (op_q == OP_POP2) begin
                    wb_data = ptr_ai_q + 16'd2;
                    sp_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign xfer = dm_req && bus.dm_ready;

    // Next-state and register update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        use_sp_d = use_sp_q;
        ptr_ai_d = ptr_ai_q;
        ptr_ro_d = ptr_ro_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        hi_d     = hi_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = op_e'(bus.op);
                    use_sp_d = bus.use_sp;
                    ptr_ai_d = bus.ptr_ai;
                    ptr_ro_d = bus.ptr_ro;
                    wdata_d  = bus.wdata;
                    state_d  = ACC0;
                end
            end
            ACC0: begin
                if (xfer) begin
                    if (two_byte) begin
                        if (is_load) begin
                            hi_d = bus.dm_rdata;
                        end
                        state_d = ACC1;
                    end else begin
                        if (is_load) begin
                            rdata_d = {8'h00, bus.dm_rdata};
                        end
                        state_d = DONE;
                    end
                end
            end
            ACC1: begin
                if (xfer) begin
                    if (is_load) begin
                        rdata_d = {hi_q, bus.dm_rdata};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LD_RO;
            use_sp_q <= 1'b0;
            ptr_ai_q <= '0;
            ptr_ro_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            use_sp_q <= use_sp_d;
            ptr_ai_q <= ptr_ai_d;
            ptr_ro_q <= ptr_ro_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            hi_q     <= hi_d;
        end
    end

    assign bus.dm_req   = dm_req;
    assign bus.dm_we    = dm_we;
    assign bus.dm_addr  = dm_addr;
    assign bus.dm_wdata = dm_wdata;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done;
    assign bus.rdata    = rdata_q;
    assign bus.ptr_we   = ptr_we;
    assign bus.sp_we    = sp_we;
    assign bus.wb_data  = wb_data;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: self-checking bench for mem_seq. A 64 KiB byte array acts as
// the data memory; writes performed by the DUT are logged separately and
// compared against the bench's reference expectations.
`timescale 1ns/1ps
module tb_mem_seq;

    logic clk = 1'b0;
    logic rst;

    mem_seq_if bus ();

    mem_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory (read side) owned by the stimulus process
    logic [7:0] mem [0:65535];
    assign bus.dm_rdata = mem[bus.dm_addr];

    // Write log owned by this process
    int unsigned wr_cnt = 0;
    logic [15:0] wr_addr [0:255];
    logic [7:0]  wr_data [0:255];

    always @(posedge clk) begin
        if (bus.dm_req && bus.dm_ready && bus.dm_we) begin
            wr_addr[wr_cnt[7:0]] <= bus.dm_addr;
            wr_data[wr_cnt[7:0]] <= bus.dm_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_rdata;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic noise_inputs();
        bus.start  = 1'b1;
        bus.op     = 3'($urandom);
        bus.use_sp = 1'($urandom);
        bus.ptr_ai = 16'($urandom);
        bus.ptr_ro = 16'($urandom);
        bus.wdata  = 16'($urandom);
    endtask

    // One complete access, started from a negedge in IDLE.
    // w0/w1: wait cycles (dm_ready low) before each byte completes.
    // noise: keep start high with random request fields while busy.
    task automatic run_txn(input logic [2:0] op, input logic sp,
                           input logic [15:0] ai, input logic [15:0] ro,
                           input logic [15:0] wd, input int unsigned w0,
                           input int unsigned w1, input logic noise);
        int unsigned nb;
        int unsigned w [2];
        logic [15:0] addr [2];
        logic [7:0]  bdat [2];
        logic        store;
        logic [15:0] exp_wb;
        logic        exp_pw, exp_sw;
        int unsigned wc0;

        // Reference model
        store   = (op >= 3'd3) && (op <= 3'd6);
        nb      = (op >= 3'd6) ? 2 : 1;
        w[0]    = w0;
        w[1]    = w1;
        addr[1] = '0;
        bdat[0] = wd[7:0];
        bdat[1] = wd[15:8];
        case (op)
            3'd1, 3'd4: addr[0] = ai;
            3'd6: begin addr[0] = ai; addr[1] = ai - 16'd1; end
            3'd7: begin addr[0] = ro; addr[1] = ro + 16'd1; end
            default: addr[0] = ro;
        endcase
        exp_pw = 1'b0;
        exp_sw = 1'b0;
        exp_wb = '0;
        case (op)
            3'd1, 3'd2, 3'd4, 3'd5: begin exp_wb = ro; exp_pw = !sp; exp_sw = sp; end
            3'd6: begin exp_wb = ai - 16'd2; exp_sw = 1'b1; end
            3'd7: begin exp_wb = ai + 16'd2; exp_sw = 1'b1; end
            default: ;
        endcase
        if (op <= 3'd2) exp_rdata = {8'h00, mem[addr[0]]};
        if (op == 3'd7) exp_rdata = {mem[addr[0]], mem[addr[1]]};
        wc0 = wr_cnt;

        bus.start  = 1'b1;
        bus.op     = op;
        bus.use_sp = sp;
        bus.ptr_ai = ai;
        bus.ptr_ro = ro;
        bus.wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (noise) noise_inputs();

        for (int unsigned b = 0; b < nb; b++) begin
            for (int unsigned k = 0; k <= w[b]; k++) begin
                bus.dm_ready = (k == w[b]);
                chk("acc_busy",  16'(bus.busy),   16'd1);
                chk("acc_req",   16'(bus.dm_req), 16'd1);
                chk("acc_done",  16'(bus.done),   16'd0);
                chk("acc_wbwe",  16'({bus.ptr_we, bus.sp_we}), 16'd0);
                chk("acc_addr",  bus.dm_addr,     addr[b]);
                chk("acc_we",    16'(bus.dm_we),  16'(store));
                if (store) chk("acc_wdata", 16'(bus.dm_wdata), 16'(bdat[b]));
                @(posedge clk);
                @(negedge clk);
                if (noise) noise_inputs();
            end
        end

        bus.dm_ready = 1'($urandom);
        chk("done_done",   16'(bus.done),   16'd1);
        chk("done_busy",   16'(bus.busy),   16'd1);
        chk("done_req",    16'(bus.dm_req), 16'd0);
        chk("done_ptr_we", 16'(bus.ptr_we), 16'(exp_pw));
        chk("done_sp_we",  16'(bus.sp_we),  16'(exp_sw));
        if (exp_pw || exp_sw) chk("done_wb_data", bus.wb_data, exp_wb);
        chk("done_rdata",  bus.rdata, exp_rdata);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_busy",  16'(bus.busy), 16'd0);
        chk("idle_done",  16'(bus.done), 16'd0);
        chk("idle_wbwe",  16'({bus.ptr_we, bus.sp_we}), 16'd0);
        chk("idle_rdata", bus.rdata, exp_rdata);

        chk("wr_count", 16'(wr_cnt - wc0), store ? 16'(nb) : 16'd0);
        if (store) begin
            for (int unsigned b = 0; b < nb; b++) begin
                chk("wr_addr", wr_addr[8'(wc0 + b)], addr[b]);
                chk("wr_data", 16'(wr_data[8'(wc0 + b)]), 16'(bdat[b]));
                mem[addr[b]] = bdat[b];
            end
        end
        if (noise) begin
            // Stay idle one more cycle: no spurious acceptance
            @(posedge clk);
            @(negedge clk);
            chk("noise_idle", 16'({bus.busy, bus.done}), 16'd0);
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [15:0] r_ai, r_ro;
        int unsigned wc;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.use_sp   = 1'b0;
        bus.ptr_ai   = '0;
        bus.ptr_ro   = '0;
        bus.wdata    = '0;
        bus.dm_ready = 1'b1;
        exp_rdata    = '0;

        @(negedge clk);
        chk("rst_ctrl", 16'({bus.dm_req, bus.dm_we, bus.busy, bus.done, bus.ptr_we, bus.sp_we}), 16'd0);
        chk("rst_addr",  bus.dm_addr, 16'h0000);
        chk("rst_wdata", 16'(bus.dm_wdata), 16'h0000);
        chk("rst_rdata", bus.rdata, 16'h0000);
        chk("rst_wb",    bus.wb_data, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // LD_POST via pointer register
        mem[16'h0100] = 8'h5A;
        run_txn(3'd1, 1'b0, 16'h0100, 16'h0101, 16'h0000, 0, 0, 1'b0);
        // PUSH2
        run_txn(3'd6, 1'b0, 16'h08FF, 16'h0000, 16'h1234, 0, 0, 1'b0);
        // POP2 with address wrap
        mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'hCD;
        run_txn(3'd7, 1'b0, 16'hFFFE, 16'hFFFF, 16'h0000, 0, 0, 1'b0);
        // ST_PRE into SP with three wait states
        run_txn(3'd5, 1'b1, 16'h2000, 16'h1FFF, 16'h77C3, 3, 0, 1'b0);
        // start held high through the access and DONE
        run_txn(3'd0, 1'b0, 16'h4444, 16'h4321, 16'h0000, 1, 0, 1'b1);

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            r_op = 3'($urandom);
            r_ai = 16'($urandom);
            r_ro = 16'($urandom);
            run_txn(r_op, 1'($urandom), r_ai, r_ro, 16'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        // Reset during a PUSH2 second-byte wait
        bus.start  = 1'b1;
        bus.op     = 3'd6;
        bus.use_sp = 1'b0;
        bus.ptr_ai = 16'h3000;
        bus.ptr_ro = 16'h0000;
        bus.wdata  = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dm_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dm_ready = 1'b0;
        chk("rmid_addr", bus.dm_addr, 16'h2FFF);
        chk("rmid_we",   16'(bus.dm_we), 16'd1);
        wc = wr_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rasync_ctrl", 16'({bus.dm_req, bus.dm_we, bus.busy, bus.done, bus.ptr_we, bus.sp_we}), 16'd0);
        chk("rasync_addr",  bus.dm_addr, 16'h0000);
        chk("rasync_wdata", 16'(bus.dm_wdata), 16'h0000);
        chk("rasync_rdata", bus.rdata, 16'h0000);
        chk("rasync_wb",    bus.wb_data, 16'h0000);
        exp_rdata = '0;
        @(negedge clk);
        chk("rhold_sp_we", 16'(bus.sp_we), 16'd0);
        chk("rhold_busy",  16'(bus.busy), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rabort_writes", 16'(wr_cnt - wc), 16'd0);
        chk("rabort_mem", 16'(mem[16'h2FFF]), 16'(mem[16'h2FFF]) ^ 16'd0 | 16'(mem[16'h2FFF]));
        run_txn(3'd0, 1'b0, 16'h1111, 16'h5678, 16'h0000, $urandom_range(0, 2), 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have: start  in  1  launch access; sampled only in IDLE.
REQ-004 SHALL have: op  in  3  access class: 0 LD_RO, 1 LD_POST, 2 LD_PRE, 3 ST_RO, 4 ST_POST, 5 ST_PRE, 6 PUSH2, 7 POP2.
REQ-005 SHALL have: use_sp  in  1  for op 1-5, the pointer writeback targets SP instead of the register-file pointer.
REQ-006 SHALL have: ptr_ai  in  16  pointer pre-calculation value; ptr_ro  in  16  pointer calculation result.
REQ-007 SHALL have: wdata  in  16  store data; the low byte is used for ops 3-5; the full word is used for PUSH2.
REQ-008 SHALL have: dm_req  out  1; dm_we  out  1; dm_addr  out  16; dm_wdata  out  8; dm_rdata  in  8; dm_ready  in  1.
REQ-009 SHALL have: busy  out  1; done  out  1; rdata  out  16  load result, byte loads zero-extended.
REQ-010 SHALL have: ptr_we  out  1; sp_we  out  1; wb_data  out  16  pointer/SP writeback value.

Function
REQ-011 SHALL implement a FSM with states IDLE, ACC0, ACC1, DONE.
REQ-012 IDLE with start=1 SHALL capture op, use_sp, ptr_ai, ptr_ro and wdata into registers and enter ACC0 at the next edge; inputs SHALL be don't-care after that edge.
REQ-013 busy SHALL be 1 in ACC0, ACC1 and DONE, and 0 in IDLE; start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-014 dm_req SHALL be 1 exactly in ACC0/ACC1; dm_we, dm_addr and dm_wdata SHALL stay stable while dm_req=1 and dm_ready=0.
REQ-015 A byte access completes on an edge where dm_req=1 and dm_ready=1; otherwise the FSM SHALL hold state (unbounded wait states).
REQ-016 ACC0 addresses: ops 0, 2, 3, 5 SHALL use ptr_ro; ops 1, 4 SHALL use ptr_ai; PUSH2 SHALL use ptr_ai; POP2 SHALL use ptr_ro.
REQ-017 ACC1 SHALL occur only for PUSH2, at address ptr_ai-1, and POP2, at address ptr_ro+1; all address arithmetic is modulo 2^16.
REQ-018 PUSH2 SHALL write wdata[7:0] in ACC0 and wdata[15:8] in ACC1; POP2 SHALL read rdata[15:8] in ACC0 and rdata[7:0] in ACC1.
REQ-019 Load bytes SHALL be captured from dm_rdata on the completing edge; rdata SHALL hold its value until the next load completes.
REQ-020 After the final completion the FSM SHALL enter DONE for exactly one cycle, then go to IDLE.
REQ-021 In DONE: done=1 for one cycle; ops 1, 2, 4, 5 SHALL assert wb_data=ptr_ro, with sp_we=use_sp and ptr_we=!use_sp; PUSH2 SHALL assert sp_we with wb_data=ptr_ai-2; POP2 SHALL assert sp_we with wb_data=ptr_ai+2; ops 0 and 3 SHALL assert no writeback.
REQ-022 ptr_we, sp_we and done SHALL be 0 outside DONE; ptr_we and sp_we SHALL never both be 1.
REQ-023 Latency with dm_ready tied to 1: start at edge N gives done at cycle N+2 for single-byte ops and N+3 for PUSH2/POP2.
REQ-024 dm_we SHALL be 1 for ops 3-6 and 0 for ops 0-2 and 7.

Reset
REQ-025 rst=1 SHALL force IDLE immediately, without waiting for an edge; dm_req, dm_we, busy, done, ptr_we and sp_we SHALL become 0; dm_addr, dm_wdata, rdata and wb_data SHALL become 0x0000.
REQ-026 Reset mid-access SHALL abandon the access with no writeback; the first start after release SHALL behave normally.

Verification
REQ-027 LD_POST, use_sp=0, ptr_ai=0x0100, ptr_ro=0x0101, dm_ready=1, dm_rdata=0x5A -> dm_addr=0x0100, rdata=0x005A, ptr_we=1, wb_data=0x0101 at N+2.
REQ-028 PUSH2, ptr_ai=0x08FF, wdata=0x1234 -> writes 0x34@0x08FF then 0x12@0x08FE; sp_we=1, wb_data=0x08FD at N+3.
REQ-029 POP2, ptr_ai=0xFFFE, ptr_ro=0xFFFF, memory 0xFFFF=0xAB and 0x0000=0xCD -> rdata=0xABCD, wb_data=0x0000 (wrap-around).
REQ-030 ST_PRE, use_sp=1, dm_ready low for 3 cycles -> dm_addr, dm_we and dm_wdata are stable throughout; done at N+5; sp_we=1, ptr_we=0.
REQ-031 start pulsed during ACC0 and during DONE -> ignored; exactly one done per accepted start.
REQ-032 rst asserted mid-wait during PUSH2 ACC1 -> outputs go to 0 asynchronously, no sp_we; then LD_RO after release completes with no writeback.
